wide_ser: RTL and testbench

WIDE_SER -- requirements
Module: wide_ser

---
 rtl/wide_ser.sv | 162 ++++++++++++++++
 tb/tb_wide_ser.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wide_ser.sv
// wide_ser: frame-to-beat serializer.
//   Accepts an F-bit frame (NWORDS words of DATA_W bits) on a valid/ready
//   handshake and emits it as B = F/OUT_W beats of OUT_W bits. The
//   msb_first flag is captured with the frame and selects which end of the
//   frame is sent first.
// Optional feature macro: WIDE_SER_PRELOAD_EN. When defined, a holding
//   register accepts the next frame while the current one is still
//   shifting, so back-to-back frames stream with no idle cycle.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active low
//   in_valid   frame offered
//   in_ready   frame accepted on in_valid && in_ready (registered)
//   in_data    frame, word NWORDS-1 most significant
//   msb_first  1: top OUT_W bits first, 0: bits [OUT_W-1:0] first
//   out_valid  out_data holds a valid beat
//   out_ready  beat consumed on out_valid && out_ready
//   out_data   current beat
//   out_last   final beat of the frame
//   done       one-cycle pulse after the final beat is consumed
module wide_ser #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned NWORDS = 2,
    parameter int unsigned OUT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NWORDS*DATA_W-1:0] in_data,
    input  logic                     msb_first,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         out_data,
    output logic                     out_last,
    output logic                     done
);

    localparam int unsigned F     = NWORDS * DATA_W;
    localparam int unsigned B     = F / OUT_W;
    localparam int unsigned CNT_W = (B > 1) ? $clog2(B) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(B - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]       state, state_nxt;
    logic [F-1:0]     sh, sh_nxt;
    logic             ord, ord_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             rdy_nxt, last_nxt, done_nxt;
    logic             accept, fire, fire_last;

`ifdef WIDE_SER_PRELOAD_EN
    logic [F-1:0]     hold, hold_nxt;
    logic             hold_ord, hold_ord_nxt;
    logic             hold_v, hold_v_nxt;
`endif

    assign accept    = in_valid && in_ready;
    assign fire      = out_valid && out_ready;
    assign fire_last = fire && (cnt == CNT_MAX);

    // Output beat is a fixed slice of the shift register; which end depends on order.
    assign out_valid = (state == SHIFT);
    assign out_data  = ord ? sh[F-1 -: OUT_W] : sh[OUT_W-1:0];

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            sh       <= '0;
            ord      <= 1'b0;
            cnt      <= '0;
            in_ready <= 1'b0;
            out_last <= 1'b0;
            done     <= 1'b0;
`ifdef WIDE_SER_PRELOAD_EN
            hold     <= '0;
            hold_ord <= 1'b0;
            hold_v   <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            sh       <= sh_nxt;
            ord      <= ord_nxt;
            cnt      <= cnt_nxt;
            in_ready <= rdy_nxt;
            out_last <= last_nxt;
            done     <= done_nxt;
`ifdef WIDE_SER_PRELOAD_EN
            hold     <= hold_nxt;
            hold_ord <= hold_ord_nxt;
            hold_v   <= hold_v_nxt;
`endif
        end
    end

    // Next-state, shift and handshake logic.
    always_comb begin
        state_nxt = state;
        sh_nxt    = sh;
        ord_nxt   = ord;
        cnt_nxt   = cnt;
        done_nxt  = fire_last;
`ifdef WIDE_SER_PRELOAD_EN
        hold_nxt     = hold;
        hold_ord_nxt = hold_ord;
        hold_v_nxt   = hold_v;
`endif

        // Consumed beat: move the next beat toward the output end, zero fill.
        if (fire) begin
            sh_nxt  = ord ? (sh << OUT_W) : (sh >> OUT_W);
            cnt_nxt = fire_last ? '0 : cnt + CNT_W'(1);
        end

        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SHIFT;
                    sh_nxt    = in_data;
                    ord_nxt   = msb_first;
                    cnt_nxt   = '0;
                end
            end
            default: begin
`ifdef WIDE_SER_PRELOAD_EN
                if (fire_last) begin
                    // Held frame takes priority; in_ready is low whenever hold is full.
                    if (hold_v) begin
                        sh_nxt     = hold;
                        ord_nxt    = hold_ord;
                        hold_v_nxt = 1'b0;
                    end else if (accept) begin
                        sh_nxt  = in_data;
                        ord_nxt = msb_first;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (accept) begin
                    hold_nxt     = in_data;
                    hold_ord_nxt = msb_first;
                    hold_v_nxt   = 1'b1;
                end
`else
                if (fire_last) begin
                    state_nxt = IDLE;
                end
`endif
            end
        endcase

`ifdef WIDE_SER_PRELOAD_EN
        rdy_nxt = !hold_v_nxt;
`else
        rdy_nxt = (state_nxt == IDLE);
`endif
        last_nxt = (state_nxt == SHIFT) && (cnt_nxt == CNT_MAX);
    end

endmodule

// File: tb/tb_wide_ser.sv
// tb_wide_ser: self-checking bench for wide_ser (default parameters plus a
// DATA_W=32/NWORDS=3/OUT_W=16 instance). A queue-based model of expected
// beats is checked against the DUT every cycle; directed literals pin it.
module tb_wide_ser;

    localparam int unsigned F  = 128;
    localparam int unsigned OW = 8;
    localparam int unsigned B  = 16;
`ifdef WIDE_SER_PRELOAD_EN
    localparam bit PRE = 1'b1;
`else
    localparam bit PRE = 1'b0;
`endif

    localparam logic [F-1:0] FRAME_A = 128'h0011223344556677_8899AABBCCDDEEFF;
    localparam logic [F-1:0] FRAME_B = 128'h0123456789ABCDEF_FEDCBA9876543210;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic [F-1:0]  in_data   = '0;
    logic          msb_first = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [OW-1:0] out_data;
    logic          out_last;
    logic          done;

    wide_ser dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .msb_first(msb_first),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .done(done)
    );

    logic        in_valid2  = 1'b0;
    logic        in_ready2;
    logic [95:0] in_data2   = '0;
    logic        msb2       = 1'b1;
    logic        out_valid2;
    logic        out_ready2 = 1'b1;
    logic [15:0] out_data2;
    logic        out_last2;
    logic        done2;

    wide_ser #(.DATA_W(32), .NWORDS(3), .OUT_W(16)) dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2), .msb_first(msb2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
        .out_last(out_last2), .done(done2)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input bit ok, input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model state: beats still to be delivered, each {last, data}.
    logic [8:0]  q[$];
    logic [7:0]  flog[$];
    bit          done_exp = 1'b0;
    bit          chk_en   = 1'b0;
    bit          gap_arm  = 1'b0;
    int          gap      = 0;
    int          n55      = 0;
    int          up       = 0;
    bit          vexp, rexp, fire;

    // Edges since reset release; in_ready may only rise after the first one.
    always @(posedge clk or negedge rst) begin
        if (!rst) up <= 0;
        else if (up < 1000) up <= up + 1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            if (!rst) begin
                check({out_valid, out_last, done, in_ready, out_data} == 12'h0, "reset_outputs",
                      {out_valid, out_last, done, in_ready, out_data}, 0);
                q.delete();
                done_exp = 1'b0;
            end else begin
                vexp = (q.size() > 0);
                rexp = (up > 0) && (PRE ? (q.size() <= B) : (q.size() == 0));
                check(out_valid == vexp, "out_valid", out_valid, vexp);
                if (vexp && out_valid) begin
                    check(out_data == q[0][7:0], "out_data", out_data, q[0][7:0]);
                    check(out_last == q[0][8], "out_last", out_last, q[0][8]);
                end
                check(in_ready == rexp, "in_ready", in_ready, rexp);
                check(done == done_exp, "done", done, done_exp);
                if (gap_arm && flog.size() > 0 && !out_valid) gap++;
                if (out_valid && out_data == 8'h55) n55++;
                fire     = vexp && out_ready;
                done_exp = fire && q[0][8];
                if (fire) begin
                    flog.push_back(out_data);
                    void'(q.pop_front());
                end
                if (in_valid && rexp) begin
                    for (int i = 0; i < B; i++) begin
                        logic [7:0] bt;
                        bt = msb_first ? 8'(in_data >> (F - (i + 1) * OW)) : 8'(in_data >> (i * OW));
                        q.push_back({i == B - 1, bt});
                    end
                end
            end
        end
    end

    // Called at posedge+#1; returns at posedge+#1 after the accepting edge.
    task automatic send(input logic [F-1:0] d, input logic m);
        int n;
        n = 0;
        in_data = d; msb_first = m; in_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        if (!in_ready) check(1'b0, "send_timeout", n, 200);
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = '0; msb_first = 1'b0;
    endtask

    task automatic wait_beats(input int n, input string nm);
        int k;
        k = 0;
        while (flog.size() < n && k < 500) begin
            @(posedge clk); #1;
            k++;
        end
        check(flog.size() == n, nm, flog.size(), n);
    endtask

    task automatic wait_out(input logic [7:0] v);
        int k;
        k = 0;
        while (!(out_valid && out_data == v) && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        check(out_valid && out_data == v, "wait_beat", out_data, v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        #2 rst = 1'b0;
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        check(in_ready == 1'b1, "ready_after_reset", in_ready, 1);

        // msb-first frame
        flog.delete();
        send(FRAME_A, 1'b1);
        wait_beats(B, "msb_beat_count");
        for (int i = 0; i < B; i++) check(flog[i] == 8'(i * 17), "msb_beat", flog[i], 8'(i * 17));
        repeat (3) @(posedge clk); #1;

        // lsb-first frame
        flog.delete();
        send(FRAME_A, 1'b0);
        wait_beats(B, "lsb_beat_count");
        for (int i = 0; i < B; i++) check(flog[i] == 8'(255 - 17 * i), "lsb_beat", flog[i], 8'(255 - 17 * i));
        repeat (3) @(posedge clk); #1;

        // backpressure at beat 5
        flog.delete();
        n55 = 0;
        fork
            send(FRAME_A, 1'b1);
            begin
                wait_out(8'h55);
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_beats(B, "stall_beat_count");
        check(n55 == 4, "stall_hold_cycles", n55, 4);
        for (int i = 0; i < B; i++) check(flog[i] == 8'(i * 17), "stall_beat", flog[i], 8'(i * 17));
        repeat (3) @(posedge clk); #1;

        // reset mid-frame at beat 7
        fork
            send(FRAME_A, 1'b1);
            begin
                wait_out(8'h77);
                rst = 1'b0;
                repeat (2) @(posedge clk);
                #1 rst = 1'b1;
            end
        join
        @(posedge clk); #1;
        check(in_ready == 1'b1, "ready_after_midreset", in_ready, 1);
        flog.delete();
        send(FRAME_A, 1'b1);
        wait_beats(B, "post_reset_count");
        check(flog[0] == 8'h00, "post_reset_first", flog[0], 0);
        repeat (3) @(posedge clk); #1;

        // back-to-back frames
        flog.delete();
        gap = 0;
        gap_arm = 1'b1;
        send(FRAME_A, 1'b1);
        send(FRAME_B, 1'b0);
        wait_beats(2 * B, "b2b_beat_count");
        gap_arm = 1'b0;
        check(gap == (PRE ? 0 : 1), "b2b_gap", gap, PRE ? 0 : 1);
        repeat (3) @(posedge clk); #1;

        // next frame offered while the final beat is showing
        flog.delete();
        send(FRAME_B, 1'b1);
        wait_out(8'h10);
        send(FRAME_A, 1'b0);
        wait_beats(2 * B, "late_offer_count");
        check(flog[B] == 8'hFF, "late_offer_first", flog[B], 8'hFF);
        repeat (3) @(posedge clk); #1;

        // wide-beat instance
        begin
            int k, nb;
            in_data2 = 96'h0001_0002_0003_0004_0005_0006;
            msb2 = 1'b1; in_valid2 = 1'b1;
            k = 0;
            do begin @(negedge clk); k++; end while (!in_ready2 && k < 50);
            @(posedge clk); #1 in_valid2 = 1'b0;
            nb = 0; k = 0;
            while (nb < 6 && k < 50) begin
                @(negedge clk);
                k++;
                if (out_valid2) begin
                    check(out_data2 == 16'(nb + 1), "w16_beat", out_data2, 16'(nb + 1));
                    check(out_last2 == (nb == 5), "w16_last", out_last2, nb == 5);
                    nb++;
                end
            end
            check(nb == 6, "w16_beat_count", nb, 6);
            @(negedge clk);
            check(done2 == 1'b1, "w16_done", done2, 1);
        end

        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
